// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer for a single-MAC FIR filter.
// Samples arrive on an AXI-stream-like input. The last NTAP of them are kept
// in an external data RAM used as a circular history, the tap RAM is walked
// once per sample, and each filtered result leaves on the output stream.
// Both RAMs have a one-cycle synchronous read latency.
module fir_seq_ctrl #(
    parameter int NTAP = 11,
    parameter int DW   = 32,
    parameter int AW   = 6
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          ap_start,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
    output logic          err_tlast,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    input  logic          ss_tlast,
    output logic          ss_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    input  logic          sm_tready,
    output logic [AW-1:0] tap_A,
    input  logic [DW-1:0] tap_Do,
    output logic          data_WE,
    output logic [AW-1:0] data_A,
    output logic [DW-1:0] data_Di,
    input  logic [DW-1:0] data_Do
);

    // cnt must reach NTAP (last accumulate cycle of MAC)
    localparam int CW = $clog2(NTAP + 1);
    localparam int PW = ((AW > CW) ? AW : CW) + 1;

    typedef enum logic [2:0] {IDLE, INIT, WAIT_IN, MAC, OUT, DONE} state_t;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rd_addr;
    logic [31:0]          len;
    logic [31:0]          n;
    logic signed [DW-1:0] acc;
    logic signed [DW-1:0] prod;
    logic                 is_last;
    logic                 accept;
    logic                 emit;

    // Signed product, keeping only the low DW bits (wrapping arithmetic).
    function automatic logic signed [DW-1:0] mul_trunc(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [2*DW-1:0] full;
        full = (2*DW)'(a) * (2*DW)'(b);
        return full[DW-1:0];
    endfunction

    // History slot holding the sample k steps older than the one at base.
    function automatic logic [AW-1:0] hist_addr(
        input logic [AW-1:0] base,
        input logic [CW-1:0] k
    );
        logic [PW-1:0] b;
        logic [PW-1:0] d;
        b = PW'(base);
        d = PW'(k);
        if (b >= d) begin
            return AW'(b - d);
        end
        return AW'(b + PW'(NTAP) - d);
    endfunction

    assign prod    = mul_trunc(tap_Do, data_Do);
    assign is_last = (n == len - 32'd1);
    assign accept  = ss_tvalid && ss_tready;
    assign emit    = sm_tvalid && sm_tready;
    assign rd_addr = hist_addr(wp, cnt);

    // Next-state decision for the sequencer.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_n = (data_length == 32'd0) ? DONE : INIT;
                end
            end
            INIT: begin
                if (cnt == CW'(NTAP - 1)) begin
                    state_n = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (accept) begin
                    state_n = MAC;
                end
            end
            MAC: begin
                if (cnt == CW'(NTAP)) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (emit) begin
                    state_n = (n + 32'd1 == len) ? DONE : WAIT_IN;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // RAM port drive: clear history in INIT, store the incoming sample in
    // WAIT_IN (written in the accept cycle so MAC reads it back at once),
    // and walk taps/history in the first NTAP cycles of MAC.
    always_comb begin
        tap_A   = '0;
        data_A  = '0;
        data_WE = 1'b0;
        data_Di = '0;
        case (state)
            INIT: begin
                data_WE = 1'b1;
                data_A  = AW'(cnt);
            end
            WAIT_IN: begin
                data_WE = ss_tvalid;
                data_A  = wp;
                data_Di = ss_tdata;
            end
            MAC: begin
                if (cnt < CW'(NTAP)) begin
                    tap_A  = AW'(cnt);
                    data_A = rd_addr;
                end
            end
            default: begin
            end
        endcase
    end

    // State register, registered status/handshake outputs and datapath.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            ap_idle   <= 1'b1;
            ap_done   <= 1'b0;
            err_tlast <= 1'b0;
            ss_tready <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
            cnt       <= '0;
            wp        <= '0;
            len       <= '0;
            n         <= '0;
            acc       <= '0;
        end else begin
            state     <= state_n;
            ap_idle   <= (state_n == IDLE);
            ap_done   <= (state_n == DONE);
            ss_tready <= (state_n == WAIT_IN);
            sm_tvalid <= (state_n == OUT);
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        len       <= data_length;
                        n         <= '0;
                        wp        <= '0;
                        cnt       <= '0;
                        err_tlast <= 1'b0;
                    end
                end
                INIT: begin
                    cnt <= (cnt == CW'(NTAP - 1)) ? '0 : cnt + 1'b1;
                end
                WAIT_IN: begin
                    if (accept) begin
                        cnt <= '0;
                        if (ss_tlast != is_last) begin
                            err_tlast <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    // RAM data lags the address by one cycle, so the first
                    // MAC cycle only clears and the last one finishes the sum
                    if (cnt == '0) begin
                        acc <= '0;
                    end else begin
                        acc <= acc + prod;
                    end
                    if (cnt == CW'(NTAP)) begin
                        sm_tdata <= acc + prod;
                        sm_tlast <= is_last;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (emit) begin
                        n        <= n + 32'd1;
                        wp       <= (wp == AW'(NTAP - 1)) ? '0 : wp + 1'b1;
                        sm_tlast <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: tap/data RAM models, a convolution reference model,
// a vector table of single-tap arithmetic cases and directed control cases.
module tb_fir_seq_ctrl;

    localparam int NTAP = 11;
    localparam int DW   = 32;
    localparam int AW   = 6;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          ap_start;
    logic [31:0]   data_length;
    logic          ap_idle, ap_done, err_tlast;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;
    logic          sm_tvalid, sm_tlast, sm_tready;
    logic [DW-1:0] sm_tdata;
    logic [AW-1:0] tap_A, data_A;
    logic [DW-1:0] tap_Do, data_Do, data_Di;
    logic          data_WE;
    logic          preload;

    always #5 wb_clk_i = ~wb_clk_i;

    fir_seq_ctrl #(.NTAP(NTAP), .DW(DW), .AW(AW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ap_start(ap_start),
        .data_length(data_length), .ap_idle(ap_idle), .ap_done(ap_done),
        .err_tlast(err_tlast), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
        .ss_tlast(ss_tlast), .ss_tready(ss_tready), .sm_tvalid(sm_tvalid),
        .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .tap_A(tap_A), .tap_Do(tap_Do), .data_WE(data_WE), .data_A(data_A),
        .data_Di(data_Di), .data_Do(data_Do)
    );

    logic [31:0] tmem [0:63];
    logic [31:0] dmem [0:63];
    logic [31:0] xin  [0:63];
    logic [31:0] yexp [0:63];

    // Synchronous RAM models; preload fills the history RAM with junk
    always @(posedge wb_clk_i) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hA5A50000 + 32'(i);
        end else if (data_WE) begin
            dmem[data_A] <= data_Di;
        end
        data_Do <= dmem[data_A];
        tap_Do  <= tmem[tap_A];
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int last_lat;

    typedef struct {
        logic [31:0] tap0;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: y[i] = sum_k tap[k]*x[i-k], history empty at run start, mod 2^32
    function automatic void build_expected(input int len);
        logic [31:0] s;
        for (int i = 0; i < len; i++) begin
            s = 32'h0;
            for (int k = 0; k < NTAP; k++) begin
                if (i - k >= 0) s = s + tmem[k] * xin[i - k];
            end
            yexp[i] = s;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ap_idle"},   ap_idle,   1);
        chk({tag, "_ap_done"},   ap_done,   0);
        chk({tag, "_err_tlast"}, err_tlast, 0);
        chk({tag, "_ss_tready"}, ss_tready, 0);
        chk({tag, "_sm_tvalid"}, sm_tvalid, 0);
        chk({tag, "_sm_tdata"},  sm_tdata,  0);
        chk({tag, "_sm_tlast"},  sm_tlast,  0);
        chk({tag, "_data_WE"},   data_WE,   0);
        chk({tag, "_tap_A"},     tap_A,     0);
        chk({tag, "_data_A"},    data_A,    0);
    endtask

    // ready_pct: 100 = always ready, <0 = hold first output 5 cycles,
    // otherwise random ready/valid. abort_at >= 0 resets during that sample's MAC.
    task automatic run_stream(input string tag, input int len, input int ready_pct,
                              input int bad_last, input bit poke_start,
                              input int abort_at, input bit use_model);
        int si, oi, cyc, acc_cyc, first_vld, hold_cnt;
        bit held, finished, poked, aborted;
        logic [31:0] hd;
        logic hl;
        si = 0; oi = 0; cyc = 0; acc_cyc = -1; first_vld = -1; hold_cnt = 0;
        held = 0; finished = 0; poked = 0; aborted = 0; hd = '0; hl = 1'b0;
        if (use_model) build_expected(len);
        @(negedge wb_clk_i);
        ap_start = 1'b1;
        data_length = 32'(len);
        @(negedge wb_clk_i);
        ap_start = 1'b0;
        while (cyc < 4000) begin
            if (ap_done) begin
                finished = 1;
                break;
            end
            if (held) begin
                chk($sformatf("%s_hold_data", tag), sm_tdata, hd);
                chk($sformatf("%s_hold_last", tag), sm_tlast, hl);
                chk($sformatf("%s_hold_ss_tready", tag), ss_tready, 0);
                held = 0;
            end
            if (abort_at >= 0 && si == abort_at && oi == abort_at - 1 && !ss_tready && !sm_tvalid) begin
                ss_tvalid = 1'b0;
                sm_tready = 1'b0;
                wb_rst_i  = 1'b1;
                #1;
                check_reset_outputs({tag, "_abort"});
                @(negedge wb_clk_i);
                wb_rst_i = 1'b0;
                aborted  = 1;
                break;
            end
            ap_start = 1'b0;
            if (poke_start && !poked && si == 2 && !ss_tready && !sm_tvalid) begin
                ap_start    = 1'b1;
                data_length = 32'd7;
                poked       = 1;
            end
            ss_tvalid = (si < len) && (ready_pct == 100 || ready_pct < 0 || $urandom_range(3) != 0);
            ss_tdata  = (si < len) ? xin[si] : 32'h0;
            ss_tlast  = (si == len - 1) ^ (si == bad_last);
            if (ready_pct < 0) sm_tready = (oi > 0) || (hold_cnt >= 5);
            else               sm_tready = (int'($urandom_range(99)) < ready_pct);
            if (ss_tvalid && ss_tready) begin
                if (si == 0) acc_cyc = cyc;
                si++;
            end
            if (sm_tvalid) begin
                if (first_vld < 0) first_vld = cyc;
                if (sm_tready) begin
                    if (oi >= len) begin
                        chk($sformatf("%s_extra_output", tag), oi, len - 1);
                    end else begin
                        chk($sformatf("%s_y%0d", tag, oi), sm_tdata, yexp[oi]);
                        chk($sformatf("%s_last%0d", tag, oi), sm_tlast, (oi == len - 1));
                    end
                    oi++;
                end else begin
                    held = 1; hd = sm_tdata; hl = sm_tlast; hold_cnt++;
                end
            end
            @(negedge wb_clk_i);
            cyc++;
        end
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        ap_start  = 1'b0;
        if (!aborted) begin
            chk($sformatf("%s_done_seen", tag), finished, 1);
            chk($sformatf("%s_out_count", tag), oi, len);
            chk($sformatf("%s_err_tlast", tag), err_tlast, (bad_last >= 0));
            if (finished) begin
                @(negedge wb_clk_i);
                chk($sformatf("%s_done_pulse_end", tag), ap_done, 0);
                chk($sformatf("%s_idle_after", tag), ap_idle, 1);
            end
            last_lat = first_vld - acc_cyc;
        end
    endtask

    task automatic load_taps_impulse();
        for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
        tmem[0] = 32'd0;   tmem[1] = -32'sd10; tmem[2] = -32'sd9; tmem[3] = 32'd23;
        tmem[4] = 32'd56;  tmem[5] = 32'd63;   tmem[6] = 32'd56;  tmem[7] = 32'd23;
        tmem[8] = -32'sd9; tmem[9] = -32'sd10; tmem[10] = 32'd0;
        for (int i = 0; i < 64; i++) xin[i] = 32'h0;
        xin[0] = 32'd1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd2,        32'h7FFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{32'd3,        32'd5,        32'd15};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        vecs[3] = '{32'h80000000, 32'd2,        32'd0};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'd0};
        vecs[5] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB};

        for (int i = 0; i < 64; i++) begin
            tmem[i] = 32'h0;
            xin[i]  = 32'h0;
            yexp[i] = 32'h0;
        end
        wb_rst_i = 1'b1; preload = 1'b1; ap_start = 1'b0; data_length = 32'h0;
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
        last_lat = 0;
        repeat (3) @(negedge wb_clk_i);
        check_reset_outputs("reset");
        preload  = 1'b0;
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        // Impulse response over junk-filled history RAM
        load_taps_impulse();
        run_stream("impulse", 11, 100, -1, 0, -1, 1);
        chk("latency", last_lat, NTAP + 2);

        // Backpressure: first result held for 5 cycles
        for (int i = 0; i < 64; i++) xin[i] = $urandom;
        run_stream("bp", 3, -1, -1, 0, -1, 1);
        chk("bp_latency", last_lat, NTAP + 2);

        // Single-tap arithmetic table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
            tmem[0] = vecs[v].tap0;
            xin[0]  = vecs[v].x;
            yexp[0] = vecs[v].y;
            run_stream($sformatf("vec%0d", v), 1, 100, -1, 0, -1, 0);
        end

        // Overflow plus two pointer wraps
        for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
        tmem[0] = 32'd2;
        for (int i = 0; i < 64; i++) xin[i] = $urandom;
        xin[0] = 32'h7FFFFFFF;
        run_stream("wrap2", 25, 60, -1, 0, -1, 1);

        // Random taps and data with random handshakes
        for (int i = 0; i < NTAP; i++) tmem[i] = $urandom;
        for (int i = 0; i < 64; i++) xin[i] = $urandom;
        run_stream("rand", 25, 70, -1, 0, -1, 1);

        // Zero-length run
        @(negedge wb_clk_i);
        ap_start = 1'b1; data_length = 32'd0;
        @(negedge wb_clk_i);
        ap_start = 1'b0;
        chk("len0_done",      ap_done,   1);
        chk("len0_ss_tready", ss_tready, 0);
        chk("len0_sm_tvalid", sm_tvalid, 0);
        chk("len0_data_WE",   data_WE,   0);
        @(negedge wb_clk_i);
        chk("len0_done_drop", ap_done,   0);
        chk("len0_idle",      ap_idle,   1);

        // ap_start pulsed mid-MAC must not disturb the run
        for (int i = 0; i < 64; i++) xin[i] = $urandom;
        run_stream("poke", 5, 100, -1, 1, -1, 1);

        // Early tlast on sample 3 of 5 sets sticky error
        run_stream("tlast_err", 5, 100, 2, 0, -1, 1);
        repeat (3) @(negedge wb_clk_i);
        chk("tlast_err_sticky", err_tlast, 1);
        run_stream("tlast_clear", 2, 100, -1, 0, -1, 1);

        // Reset during MAC of sample 4 (with an error flag set), then impulse
        for (int i = 0; i < 64; i++) xin[i] = $urandom | 32'h1;
        run_stream("abort", 8, 100, 1, 0, 4, 1);
        load_taps_impulse();
        run_stream("post_reset", 11, 100, -1, 0, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
